// File: rtl/process_scheduler.sv
// process_scheduler: runs NUM_STAGES sub-controllers in order with a four-phase start/end handshake and per-phase watchdog.
// Optional single-step pause between stages when STEP_MODE_EN is defined.
module process_scheduler #(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CW             = 20
) (
  input  logic                  clk,
  input  logic                  program_reset,
  input  logic                  run,
  input  logic [NUM_STAGES-1:0] stage_end,
`ifdef STEP_MODE_EN
  input  logic                  step,
`endif
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [2:0]            current_stage,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [2:0]            err_stage
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN      = 3'd1,
    RELEASE  = 3'd2,
    HOLD     = 3'd3,
    COMPLETE = 3'd4,
    ERROR    = 3'd5
  } state_t;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST = 3'(NUM_STAGES - 1);
`ifdef STEP_MODE_EN
  localparam state_t ADV = HOLD;
`else
  localparam state_t ADV = RUN;
`endif
  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d, err_stage_q, err_stage_d;
  logic [CW-1:0] timer_q, timer_d;
  logic          timeout_err_q, timeout_err_d;
  logic          end_cur, hs;
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    timer_d       = timer_q;
    err_stage_d   = err_stage_q;
    timeout_err_d = timeout_err_q;
    end_cur       = |(stage_end & (NUM_STAGES'(1) << idx_q));
    hs            = (state_q == RUN) ? end_cur : !end_cur;
    case (state_q)
      IDLE: if (run) begin
        state_d       = RUN;
        idx_d         = '0;
        timer_d       = '0;
        timeout_err_d = 1'b0;
      end
      RUN, RELEASE: begin
        // handshake completion has priority over a watchdog expiring in the same cycle
        if (hs) begin
          timer_d = '0;
          if (state_q == RUN) state_d = RELEASE;
          else if (idx_q == LAST) state_d = COMPLETE;
          else begin
            idx_d   = idx_q + 3'd1;
            state_d = ADV;
          end
        end else if (timer_q == TMAX) begin
          state_d       = ERROR;
          err_stage_d   = idx_q;
          timeout_err_d = 1'b1;
        end else timer_d = timer_q + 1'b1;
      end
`ifdef STEP_MODE_EN
      HOLD: if (step) state_d = RUN;
`endif
      COMPLETE, ERROR: if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge program_reset) begin
    if (program_reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      err_stage_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      err_stage_q   <= err_stage_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign stage_start   = (state_q == RUN) ? (NUM_STAGES'(1) << idx_q) : '0;
  assign current_stage = idx_q;
  assign busy          = (state_q == RUN) || (state_q == RELEASE) || (state_q == HOLD);
  assign done          = (state_q == COMPLETE);
  assign timeout_err   = timeout_err_q;
  assign err_stage     = err_stage_q;
endmodule
